param_counter: RTL and testbench

Parametrised up/down modulo counter: the next generation of the lab's 4-bit clearable counter. Adds configurable width and modulus, direction control, synchronous load, an enable prescaler, wrap-or-saturate terminal behaviour, and status outputs (terminal count, step strobe, sticky overflow). It is a drop-in sequential building block for timers, dividers and address generators in later labs.

---
 rtl/counter_pkg.sv | 29 ++
 rtl/count_prescaler.sv | 39 +++
 rtl/param_counter.sv | 108 ++++++++++
 tb/tb_param_counter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared counter helpers: prescaler sizing and terminal values.
// Used by param_counter and the timer blocks built on top of it.
package counter_pkg;

   localparam int TERM_DN = 0;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      for (int i = 0; i < 32; i++) begin
         if (x > 0) begin
            r = r + 1;
            x = x >> 1;
         end
      end
      return r;
   endfunction

   function automatic int term_up(input int modulus);
      return modulus - 1;
   endfunction

   function automatic int pre_width(input int prescale);
      return (clog2(prescale) < 1) ? 1 : clog2(prescale);
   endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enable prescaler: one TICK per PRESCALE enabled cycles.
// SYNC_CLR discards progress; gaps in EN keep it.
module count_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic CLK,
   input  logic CLR,
   input  logic EN,
   input  logic SYNC_CLR,
   output logic TICK
);

   localparam int PW = pre_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == LAST);
   assign TICK = EN && !SYNC_CLR && wrap;

   // Count enabled cycles, restarting after the last one of a period.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         cnt <= '0;
      end else if (SYNC_CLR) begin
         cnt <= '0;
      end else if (EN) begin
         if (wrap) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + PW'(1);
         end
      end
   end

endmodule

// File: rtl/param_counter.sv
// Parametrised up/down modulo counter with load, prescaler,
// wrap-or-saturate terminal behaviour and status outputs.
module param_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   input  logic             UP,
   input  logic             CLR_OVF,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             STEP,
   output logic             OVF
);

   // One extra bit so MODULUS = 2^WIDTH still fits.
   localparam logic [WIDTH:0] MODX = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] TUPX = (WIDTH+1)'(term_up(MODULUS));
   localparam logic [WIDTH:0] TDNX = (WIDTH+1)'(TERM_DN);
   localparam logic [WIDTH-1:0] TUP = TUPX[WIDTH-1:0];
   localparam logic [WIDTH-1:0] TDN = TDNX[WIDTH-1:0];

   logic [WIDTH:0]   qx;
   logic [WIDTH:0]   dx;
   logic             at_up;
   logic             at_dn;
   logic             tick;
   logic             ovf_ev;
   logic [WIDTH-1:0] q_nx;
   logic             stp_nx;
   logic             ovf_nx;

   assign qx    = {1'b0, Q};
   assign dx    = {1'b0, D};
   assign at_up = (qx == TUPX);
   assign at_dn = (qx == TDNX);
   assign TC    = UP ? at_up : at_dn;

   count_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_pre (
      .CLK     (CLK),
      .CLR     (CLR),
      .EN      (EN),
      .SYNC_CLR(LOAD),
      .TICK    (tick)
   );

   // Next count: load with clamp, else step in the sampled direction.
   always_comb begin
      q_nx   = Q;
      stp_nx = 1'b0;
      ovf_ev = 1'b0;
      if (LOAD) begin
         q_nx = (dx < MODX) ? D : TUP;
      end else if (tick) begin
         stp_nx = 1'b1;
         if (UP) begin
            if (at_up) begin
               ovf_ev = 1'b1;
               q_nx   = (SATURATE != 0) ? Q : TDN;
            end else begin
               q_nx = Q + WIDTH'(1);
            end
         end else begin
            if (at_dn) begin
               ovf_ev = 1'b1;
               q_nx   = (SATURATE != 0) ? Q : TUP;
            end else begin
               q_nx = Q - WIDTH'(1);
            end
         end
      end
   end

   // Sticky overflow: a same-edge event beats the clear.
   always_comb begin
      ovf_nx = OVF;
      if (CLR_OVF) begin
         ovf_nx = 1'b0;
      end
      if (ovf_ev) begin
         ovf_nx = 1'b1;
      end
   end

   // Output registers, cleared asynchronously.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         Q    <= '0;
         STEP <= 1'b0;
         OVF  <= 1'b0;
      end else begin
         Q    <= q_nx;
         STEP <= stp_nx;
         OVF  <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: four configurations share
// stimulus; an arithmetic model predicts each edge's outputs.
module tb_param_counter;

   typedef struct {
      int q;
      int st;
      int ov;
      int tc;
   } exp_t;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic       EN = 1'b0;
   logic       LOAD = 1'b0;
   logic [3:0] D = '0;
   logic       UP = 1'b1;
   logic       CLR_OVF = 1'b0;

   logic [3:0] q0, q1, q2;
   logic [2:0] q3;
   logic [3:0] tc, st, ov;
   logic [3:0] aq [4];

   int total = 0;
   int bad = 0;

   exp_t sb [4][$];
   int mq [4];
   int mp [4];
   int mo [4];
   int mm [4] = '{10, 10, 10, 8};
   int pp [4] = '{1, 1, 3, 2};
   int ss [4] = '{0, 1, 0, 1};
   int dm [4] = '{15, 15, 15, 7};

   always #5 CLK = ~CLK;

   param_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) d0 (
      .CLK(CLK), .CLR(CLR), .EN(EN), .LOAD(LOAD), .D(D), .UP(UP),
      .CLR_OVF(CLR_OVF), .Q(q0), .TC(tc[0]), .STEP(st[0]), .OVF(ov[0]));
   param_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) d1 (
      .CLK(CLK), .CLR(CLR), .EN(EN), .LOAD(LOAD), .D(D), .UP(UP),
      .CLR_OVF(CLR_OVF), .Q(q1), .TC(tc[1]), .STEP(st[1]), .OVF(ov[1]));
   param_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) d2 (
      .CLK(CLK), .CLR(CLR), .EN(EN), .LOAD(LOAD), .D(D), .UP(UP),
      .CLR_OVF(CLR_OVF), .Q(q2), .TC(tc[2]), .STEP(st[2]), .OVF(ov[2]));
   param_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(2), .SATURATE(1)) d3 (
      .CLK(CLK), .CLR(CLR), .EN(EN), .LOAD(LOAD), .D(D[2:0]), .UP(UP),
      .CLR_OVF(CLR_OVF), .Q(q3), .TC(tc[3]), .STEP(st[3]), .OVF(ov[3]));

   assign aq[0] = q0;
   assign aq[1] = q1;
   assign aq[2] = q2;
   assign aq[3] = {1'b0, q3};

   task automatic chk(input string nm, input int i, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", nm, i, $time, act, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mq[i] = 0;
         mp[i] = 0;
         mo[i] = 0;
      end
   endtask

   // Drive one edge's inputs and predict every DUT's response.
   task automatic cyc(input bit en, input bit ld, input int d, input bit up, input bit cov);
      @(negedge CLK);
      EN = en;
      LOAD = ld;
      D = 4'(d);
      UP = up;
      CLR_OVF = cov;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         int dv;
         bit stp;
         bit ev;
         dv = d & dm[i];
         stp = 0;
         ev = 0;
         if (ld) begin
            mq[i] = (dv < mm[i]) ? dv : mm[i] - 1;
            mp[i] = 0;
         end else begin
            if (en) begin
               mp[i] = (mp[i] + 1) % pp[i];
               stp = (mp[i] == 0);
            end
            if (stp && up) begin
               if (mq[i] == mm[i] - 1) begin
                  ev = 1;
                  if (ss[i] == 0) mq[i] = 0;
               end else begin
                  mq[i] = mq[i] + 1;
               end
            end else if (stp) begin
               if (mq[i] == 0) begin
                  ev = 1;
                  if (ss[i] == 0) mq[i] = mm[i] - 1;
               end else begin
                  mq[i] = mq[i] - 1;
               end
            end
         end
         if (cov) mo[i] = 0;
         if (ev) mo[i] = 1;
         e.q = mq[i];
         e.st = stp;
         e.ov = mo[i];
         e.tc = up ? (mq[i] == mm[i] - 1) : (mq[i] == 0);
         sb[i].push_back(e);
      end
   endtask

   // Assert CLR between edges; outputs must clear with no clock.
   task automatic do_clr();
      @(negedge CLK);
      EN = 0;
      LOAD = 0;
      CLR_OVF = 0;
      #2;
      CLR = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("clr_q", i, int'(aq[i]), 0);
         chk("clr_step", i, int'(st[i]), 0);
         chk("clr_ovf", i, int'(ov[i]), 0);
      end
      @(negedge CLK);
      CLR = 0;
      model_reset();
   endtask

   // Monitor: compare each edge's outputs against the queued prediction.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (sb[i].size() > 0) begin
               exp_t e;
               e = sb[i].pop_front();
               chk("q", i, int'(aq[i]), e.q);
               chk("step", i, int'(st[i]), e.st);
               chk("ovf", i, int'(ov[i]), e.ov);
               chk("tc", i, int'(tc[i]), e.tc);
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge CLK);
      CLR = 0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rst_q", i, int'(aq[i]), 0);
         chk("rst_ovf", i, int'(ov[i]), 0);
         chk("rst_step", i, int'(st[i]), 0);
      end
      // count to 7, then clear mid-count
      repeat (7) cyc(1, 0, 0, 1, 0);
      do_clr();
      // up wrap over 12 edges
      repeat (12) cyc(1, 0, 0, 1, 0);
      // down saturate from a load of 2
      cyc(0, 1, 2, 0, 1);
      repeat (4) cyc(1, 0, 0, 0, 0);
      // prescale with enable gaps
      cyc(0, 1, 0, 1, 1);
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      repeat (4) cyc(1, 0, 0, 1, 0);
      // load clamp beats enable, then a plain OVF clear
      cyc(1, 1, 13, 1, 0);
      cyc(0, 0, 0, 1, 1);
      // overflow and OVF clear on the same edge
      cyc(0, 1, 9, 1, 0);
      cyc(1, 0, 0, 1, 1);
      cyc(0, 1, 7, 0, 0);
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 1, 0);
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_clr();
         end else begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 11) == 0,
                int'($urandom_range(0, 15)),
                $urandom_range(0, 4) != 0 ? (n / 100) % 2 == 0 : 1'($urandom),
                $urandom_range(0, 9) == 0);
         end
      end
      repeat (3) @(posedge CLK);
      #2;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (sb[i].size() != 0) begin
            bad++;
            $display("FAIL drain dut%0d left=%0d want=0", i, sb[i].size());
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
